// File: rtl/llc_trace_dispatch_pkg.sv
// Shared types and constants for the LLC trace dispatch front end:
// operation encoding, trace command codes and default address geometry.
package llc_trace_dispatch_pkg;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_LINE_BYTES = 64;
   localparam int DEF_SETS       = 16384;
   localparam int DEF_OFF_W      = $clog2(DEF_LINE_BYTES);
   localparam int DEF_IDX_W      = $clog2(DEF_SETS);
   localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

   typedef enum logic [2:0] {
      OP_PRRD     = 3'd0,
      OP_PRWR     = 3'd1,
      OP_SNP_RD   = 3'd2,
      OP_SNP_WR   = 3'd3,
      OP_SNP_RWIM = 3'd4,
      OP_SNP_INV  = 3'd5
   } llc_op_t;

   localparam logic [3:0] CMD_PRRD     = 4'd0;
   localparam logic [3:0] CMD_PRWR     = 4'd1;
   localparam logic [3:0] CMD_IFETCH   = 4'd2;
   localparam logic [3:0] CMD_SNP_RD   = 4'd3;
   localparam logic [3:0] CMD_SNP_WR   = 4'd4;
   localparam logic [3:0] CMD_SNP_RWIM = 4'd5;
   localparam logic [3:0] CMD_SNP_INV  = 4'd6;
   localparam logic [3:0] CMD_CLEAR    = 4'd8;
   localparam logic [3:0] CMD_PRINT    = 4'd9;

endpackage

// File: rtl/llc_sync_fifo.sv
// Small in-order FIFO with extra-bit pointers for full/empty detection.
// Storage is not reset; only the pointers are, so a reset discards all entries.
module llc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign rdata = mem[rd_ptr_q[PTR_W-1:0]];

   // Write the incoming entry into the slot addressed by the write pointer.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
      end
   end

   // Advance read/write pointers; reset empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/llc_trace_dispatch.sv
// LLC trace front end: decodes trace records into cache operations, queues them
// in order for the controller, handles clear/print housekeeping after draining,
// and keeps saturating counts of dispatched reads, writes and dropped commands.
module llc_trace_dispatch
   import llc_trace_dispatch_pkg::*;
#(
   parameter  int ADDR_W     = DEF_ADDR_W,
   parameter  int LINE_BYTES = DEF_LINE_BYTES,
   parameter  int SETS       = DEF_SETS,
   parameter  int FIFO_DEPTH = 4,
   parameter  int CNT_W      = 32,
   localparam int OFF_W      = $clog2(LINE_BYTES),
   localparam int IDX_W      = $clog2(SETS),
   localparam int TAG_W      = ADDR_W - IDX_W - OFF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_cmd,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output llc_op_t           out_op,
   output logic              out_ifetch,
   output logic [TAG_W-1:0]  out_tag,
   output logic [IDX_W-1:0]  out_index,
   output logic [OFF_W-1:0]  out_offset,
   input  logic              ctrl_idle,
   output logic              clear_pulse,
   output logic              print_pulse,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int ENTRY_W = 3 + 1 + ADDR_W;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DRAIN_CLR = 2'd1,
      ST_DRAIN_PRT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   llc_op_t            dec_op;
   logic               dec_ifetch;
   logic               dec_enq;
   logic               dec_clr;
   logic               dec_prt;
   logic               dec_ill;
   logic               accept;
   logic               push;
   logic               pop;
   logic               drain_done;
   logic               clr_d;
   logic               prt_d;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;
   llc_op_t            head_op;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Decode the trace command into an operation class.
   always_comb begin
      dec_op     = OP_PRRD;
      dec_ifetch = 1'b0;
      dec_enq    = 1'b1;
      dec_clr    = 1'b0;
      dec_prt    = 1'b0;
      dec_ill    = 1'b0;
      case (in_cmd)
         CMD_PRRD:     dec_op = OP_PRRD;
         CMD_IFETCH:   begin dec_op = OP_PRRD; dec_ifetch = 1'b1; end
         CMD_PRWR:     dec_op = OP_PRWR;
         CMD_SNP_RD:   dec_op = OP_SNP_RD;
         CMD_SNP_WR:   dec_op = OP_SNP_WR;
         CMD_SNP_RWIM: dec_op = OP_SNP_RWIM;
         CMD_SNP_INV:  dec_op = OP_SNP_INV;
         CMD_CLEAR:    begin dec_enq = 1'b0; dec_clr = 1'b1; end
         CMD_PRINT:    begin dec_enq = 1'b0; dec_prt = 1'b1; end
         default:      begin dec_enq = 1'b0; dec_ill = 1'b1; end
      endcase
   end

   assign in_ready   = (state_q == ST_RUN) && !fifo_full;
   assign accept     = in_valid && in_ready;
   assign push       = accept && dec_enq;
   assign out_valid  = !fifo_empty;
   assign pop        = out_valid && out_ready;
   assign drain_done = (state_q != ST_RUN) && fifo_empty && ctrl_idle && !pop;
   assign wr_entry   = {dec_op, dec_ifetch, in_addr};

   llc_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_op = llc_op_t'(head[ENTRY_W-1 -: 3]);

   // Present the head entry split into tag/index/offset; zero when the queue is empty.
   always_comb begin
      out_op     = OP_PRRD;
      out_ifetch = 1'b0;
      out_tag    = '0;
      out_index  = '0;
      out_offset = '0;
      if (!fifo_empty) begin
         out_op     = head_op;
         out_ifetch = head[ADDR_W];
         out_tag    = head[ADDR_W-1 -: TAG_W];
         out_index  = head[OFF_W +: IDX_W];
         out_offset = head[OFF_W-1:0];
      end
   end

   // Next-state logic: housekeeping commands wait for the queue and controller to go quiet.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      prt_d   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (accept && dec_clr)      state_d = ST_DRAIN_CLR;
            else if (accept && dec_prt) state_d = ST_DRAIN_PRT;
         end
         ST_DRAIN_CLR: begin
            if (drain_done) begin
               clr_d   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_DRAIN_PRT: begin
            if (drain_done) begin
               prt_d   = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State register and registered one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         clear_pulse <= 1'b0;
         print_pulse <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clear_pulse <= clr_d;
         print_pulse <= prt_d;
         err_pulse   <= accept && dec_ill;
      end
   end

   // Saturating traffic counters; a clear zeroes them together with the pulse and wins over increments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         err_cnt <= '0;
      end else if (clr_d) begin
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         err_cnt <= '0;
      end else begin
         if (pop && (head_op == OP_PRRD)) rd_cnt  <= sat_inc(rd_cnt);
         if (pop && (head_op == OP_PRWR)) wr_cnt  <= sat_inc(wr_cnt);
         if (accept && dec_ill)           err_cnt <= sat_inc(err_cnt);
      end
   end

endmodule
